// File: rtl/adder_kernel_acc_pkg.sv
// adder_kernel_acc_pkg: shared widths, accumulator states and beat sideband for the L1-distance engine.
package adder_kernel_acc_pkg;
    localparam int NBIT_DEF    = 8;
    localparam int NDATA_DEF   = 4;
    localparam int ACC_EXT_DEF = 8;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACC  = 1'b1;
    typedef struct packed {
        logic first;
        logic last;
    } beat_flags_t;
endpackage

// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe: unsigned binary adder tree, one registered level per stage, with valid/flag sideband.
module adder_tree_pipe #(
    parameter int N  = 4,
    parameter int W  = 9,
    parameter int FW = 2
)(
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic                     in_valid,
    input  logic [FW-1:0]            in_flags,
    input  logic [N*W-1:0]           in_data,
    output logic                     out_valid,
    output logic [FW-1:0]            out_flags,
    output logic [W+$clog2(N)-1:0]   out_sum
);
    localparam int L = $clog2(N);
    logic [L-1:0]         v_sr;
    logic [L-1:0][FW-1:0] f_sr;
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) v_sr <= '0;
        else       v_sr <= L'({v_sr, in_valid});
    end
    always_ff @(posedge CLK) f_sr <= (L*FW)'({f_sr, in_flags});
    for (genvar l = 0; l < L; l++) begin : lv
        localparam int M  = N >> (l + 1);
        localparam int IW = W + l;
        logic [2*M*IW-1:0]   din;
        logic [M*(IW+1)-1:0] q;
        if (l == 0) begin : g_in
            assign din = in_data;
        end else begin : g_up
            assign din = lv[l-1].q;
        end
        always_ff @(posedge CLK)
            for (int i = 0; i < M; i++)
                q[i*(IW+1) +: IW+1] <= (IW+1)'(din[2*i*IW +: IW]) + (IW+1)'(din[(2*i+1)*IW +: IW]);
    end
    assign out_valid = v_sr[L-1];
    assign out_flags = f_sr[L-1];
    assign out_sum   = lv[L-1].q;
endmodule

// File: rtl/adder_kernel_acc.sv
// adder_kernel_acc: pipelined AdderNet L1 engine, emits -sum|if-w| over a first/last delimited window.
module adder_kernel_acc
    import adder_kernel_acc_pkg::*;
#(
    parameter int NBIT    = NBIT_DEF,
    parameter int NDATA   = NDATA_DEF,
    parameter int ACC_EXT = ACC_EXT_DEF
)(
    input  logic                                       CLK,
    input  logic                                       RSTN,
    input  logic                                       i_valid,
    input  logic                                       i_first,
    input  logic                                       i_last,
    input  logic [NBIT*NDATA-1:0]                      i_if,
    input  logic [NBIT*NDATA-1:0]                      i_w,
    output logic                                       o_valid,
    output logic signed [NBIT+1+$clog2(NDATA)+ACC_EXT:0] o_sum,
    output logic                                       o_ovf,
    output logic                                       o_busy
);
    localparam int L    = $clog2(NDATA);
    localparam int DW   = NBIT + 1;
    localparam int TW   = DW + L;
    localparam int ACCW = TW + ACC_EXT;
    logic [NDATA*DW-1:0] d_n, d_q;
    logic [DW-1:0]       df;
    logic                a_v, t_v, done;
    beat_flags_t         a_f, t_f;
    logic [TW-1:0]       t_sum;
    logic [0:0]          state;
    logic [ACCW-1:0]     acc, acc_n;
    logic [ACCW:0]       sum_ext;
    logic                ovf, ovf_n, start;
    always_comb begin
        d_n = '0;
        df  = '0;
        for (int k = 0; k < NDATA; k++) begin
            df = {i_if[NBIT*k+NBIT-1], i_if[NBIT*k +: NBIT]} - {i_w[NBIT*k+NBIT-1], i_w[NBIT*k +: NBIT]};
            d_n[DW*k +: DW] = df[DW-1] ? -df : df;
        end
    end
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) a_v <= 1'b0;
        else       a_v <= i_valid;
    end
    always_ff @(posedge CLK) begin
        d_q <= d_n;
        a_f <= '{first: i_first, last: i_last};
    end
    adder_tree_pipe #(.N(NDATA), .W(DW), .FW($bits(beat_flags_t))) u_tree (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .in_valid  (a_v),
        .in_flags  (a_f),
        .in_data   (d_q),
        .out_valid (t_v),
        .out_flags (t_f),
        .out_sum   (t_sum)
    );
    // An orphan beat arriving while idle opens a window just like a first beat.
    always_comb begin
        start   = t_f.first || state == IDLE;
        sum_ext = {1'b0, acc} + (ACCW+1)'(t_sum);
        acc_n   = start ? ACCW'(t_sum) : (sum_ext[ACCW] ? '1 : sum_ext[ACCW-1:0]);
        ovf_n   = !start && (ovf || sum_ext[ACCW]);
    end
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state   <= IDLE;
            acc     <= '0;
            ovf     <= 1'b0;
            done    <= 1'b0;
            o_valid <= 1'b0;
            o_sum   <= '0;
            o_ovf   <= 1'b0;
        end else begin
            done    <= t_v && t_f.last;
            o_valid <= done;
            if (done) begin
                o_sum <= -{1'b0, acc};
                o_ovf <= ovf;
            end
            if (t_v) begin
                acc   <= acc_n;
                ovf   <= ovf_n;
                state <= t_f.last ? IDLE : ACC;
            end
        end
    end
    assign o_busy = state == ACC;
endmodule

// File: tb/tb_adder_kernel_acc.sv
// tb_adder_kernel_acc: directed and randomized checks of the L1 engine against a window-level model.
module tb_adder_kernel_acc;
    localparam int NBIT    = 8;
    localparam int NDATA   = 4;
    localparam int ACC_EXT = 0;
    localparam int ACCW    = NBIT + 1 + 2 + ACC_EXT;
    localparam int MAXACC  = (1 << ACCW) - 1;
    localparam int LAT     = 4;

    logic CLK = 1'b0, RSTN = 1'b0;
    logic i_valid = 1'b0, i_first = 1'b0, i_last = 1'b0;
    logic [NBIT*NDATA-1:0] i_if = '0, i_w = '0;
    logic o_valid, o_ovf, o_busy;
    logic signed [ACCW:0] o_sum;

    typedef struct {int cyc; int sum; bit ovf;} res_t;
    res_t exp_q[$], obs_q[$];
    int cyc = 0, n_run = 0, n_fail = 0;
    bit open = 0, m_ovf = 0;
    int m_acc = 0;

    adder_kernel_acc #(.NBIT(NBIT), .NDATA(NDATA), .ACC_EXT(ACC_EXT)) dut (
        .CLK(CLK), .RSTN(RSTN), .i_valid(i_valid), .i_first(i_first), .i_last(i_last),
        .i_if(i_if), .i_w(i_w), .o_valid(o_valid), .o_sum(o_sum), .o_ovf(o_ovf), .o_busy(o_busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (o_valid) obs_q.push_back('{cyc, int'(o_sum), o_ovf});

    function automatic logic [31:0] pack(int a0, int a1, int a2, int a3);
        return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    // Drive one cycle; accepted beats update the window model at their accept edge.
    task automatic beat(bit v, bit f, bit l, logic [31:0] a, logic [31:0] b);
        int s = 0;
        i_valid = v; i_first = f; i_last = l; i_if = a; i_w = b;
        @(posedge CLK); #1;
        if (v) begin
            for (int k = 0; k < NDATA; k++) begin
                int x;
                x = $signed(a[8*k +: 8]) - $signed(b[8*k +: 8]);
                s += (x < 0) ? -x : x;
            end
            if (f || !open) begin
                m_acc = s; m_ovf = 0;
            end else begin
                m_acc += s;
                if (m_acc > MAXACC) begin m_acc = MAXACC; m_ovf = 1; end
            end
            if (l) begin
                exp_q.push_back('{cyc + LAT, -m_acc, m_ovf});
                open = 0;
            end else open = 1;
        end
    endtask

    task automatic idle(int n);
        repeat (n) beat(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge CLK);
        #1;
        n_run++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", o_valid); end
        n_run++; if (o_sum !== '0)     begin n_fail++; $display("FAIL reset_sum got %0d want 0", o_sum); end
        n_run++; if (o_ovf !== 1'b0)   begin n_fail++; $display("FAIL reset_ovf got %b want 0", o_ovf); end
        n_run++; if (o_busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b want 0", o_busy); end
        RSTN = 1'b1;
        idle(2);
    endtask

    task automatic test_single;
        int t;
        obs_q.delete(); exp_q.delete();
        beat(1, 1, 1, pack(10, -5, 3, 0), pack(4, -5, -3, 7));
        t = cyc;
        idle(7);
        n_run++;
        if (obs_q.size() != 1) begin n_fail++; $display("FAIL single_count got %0d want 1", obs_q.size()); end
        else begin
            n_run++; if (obs_q[0].cyc != t + LAT) begin n_fail++; $display("FAIL single_latency got cycle %0d want %0d", obs_q[0].cyc, t + LAT); end
            n_run++; if (obs_q[0].sum != -19 || obs_q[0].ovf) begin n_fail++; $display("FAIL single_value got %0d/%0b want -19/0", obs_q[0].sum, obs_q[0].ovf); end
        end
    endtask

    task automatic test_multi_bubble;
        int t;
        obs_q.delete(); exp_q.delete();
        beat(1, 1, 0, pack(1, 1, 1, 1), 0);
        beat(1, 0, 0, pack(1, 1, 1, 1), 0);
        beat(0, 0, 0, 0, 0);
        beat(1, 0, 1, pack(1, 1, 1, 1), 0);
        t = cyc;
        n_run++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL multi_busy_open got %b want 1", o_busy); end
        idle(3);
        n_run++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL multi_busy_closed got %b want 0", o_busy); end
        idle(4);
        n_run++;
        if (obs_q.size() != 1) begin n_fail++; $display("FAIL multi_count got %0d want 1", obs_q.size()); end
        else begin
            n_run++; if (obs_q[0].cyc != t + LAT || obs_q[0].sum != -12 || obs_q[0].ovf)
                begin n_fail++; $display("FAIL multi_value got %0d/%0b@%0d want -12/0@%0d", obs_q[0].sum, obs_q[0].ovf, obs_q[0].cyc, t + LAT); end
        end
    endtask

    task automatic test_saturation;
        logic [31:0] z;
        obs_q.delete(); exp_q.delete();
        z = $urandom;
        beat(1, 1, 0, pack(-128, -128, -128, -128), pack(127, 127, 127, 127));
        beat(1, 0, 0, pack(-128, -128, -128, -128), pack(127, 127, 127, 127));
        beat(1, 0, 1, pack(-128, -128, -128, -128), pack(127, 127, 127, 127));
        beat(1, 1, 1, z, z);
        idle(7);
        n_run++;
        if (obs_q.size() != 2) begin n_fail++; $display("FAIL sat_count got %0d want 2", obs_q.size()); end
        else begin
            n_run++; if (obs_q[0].sum != -2047 || !obs_q[0].ovf) begin n_fail++; $display("FAIL sat_value got %0d/%0b want -2047/1", obs_q[0].sum, obs_q[0].ovf); end
            n_run++; if (obs_q[1].sum != 0 || obs_q[1].ovf) begin n_fail++; $display("FAIL sat_clear got %0d/%0b want 0/0", obs_q[1].sum, obs_q[1].ovf); end
        end
    endtask

    task automatic test_back_to_back;
        int t;
        obs_q.delete(); exp_q.delete();
        beat(1, 1, 1, pack(10, -5, 3, 0), pack(4, -5, -3, 7));
        t = cyc;
        beat(1, 1, 1, pack(1, 1, 1, 1), 0);
        idle(7);
        n_run++;
        if (obs_q.size() != 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", obs_q.size()); end
        else begin
            n_run++; if (obs_q[0].cyc != t + LAT || obs_q[0].sum != -19) begin n_fail++; $display("FAIL b2b_first got %0d@%0d want -19@%0d", obs_q[0].sum, obs_q[0].cyc, t + LAT); end
            n_run++; if (obs_q[1].cyc != t + LAT + 1 || obs_q[1].sum != -4) begin n_fail++; $display("FAIL b2b_second got %0d@%0d want -4@%0d", obs_q[1].sum, obs_q[1].cyc, t + LAT + 1); end
        end
    endtask

    task automatic test_restart;
        obs_q.delete(); exp_q.delete();
        beat(1, 1, 0, pack(2, 2, 2, 2), 0);
        beat(1, 1, 1, pack(5, 0, 0, 0), 0);
        idle(7);
        n_run++;
        if (obs_q.size() != 1) begin n_fail++; $display("FAIL restart_count got %0d want 1", obs_q.size()); end
        else begin
            n_run++; if (obs_q[0].sum != -5 || obs_q[0].ovf) begin n_fail++; $display("FAIL restart_value got %0d/%0b want -5/0", obs_q[0].sum, obs_q[0].ovf); end
        end
    endtask

    task automatic test_reset_mid_window;
        obs_q.delete(); exp_q.delete();
        beat(1, 1, 0, pack(9, 9, 9, 9), 0);
        idle(3);
        n_run++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got %b want 1", o_busy); end
        beat(1, 0, 0, pack(9, 9, 9, 9), 0);
        beat(1, 0, 1, pack(9, 9, 9, 9), 0);
        RSTN = 1'b0;
        #1;
        n_run++; if (o_valid !== 1'b0 || o_sum !== '0 || o_ovf !== 1'b0 || o_busy !== 1'b0)
            begin n_fail++; $display("FAIL midrst_outputs got v=%b s=%0d o=%b b=%b want all 0", o_valid, o_sum, o_ovf, o_busy); end
        @(posedge CLK); #1;
        RSTN = 1'b1;
        open = 0; exp_q.delete();
        idle(8);
        n_run++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL midrst_pulse got %0d pulses want 0", obs_q.size()); end
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        obs_q.delete(); exp_q.delete();
        for (int n = 0; n < 300; n++) begin
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 3) == 0) begin a = pack(-128, -128, -128, -128); b = pack(127, 127, 127, 127); end
            beat($urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, a, b);
        end
        idle(8);
        n_run++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_run++;
            if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].sum != exp_q[i].sum || obs_q[i].ovf != exp_q[i].ovf)
                begin n_fail++; $display("FAIL rand_result[%0d] got %0d/%0b@%0d want %0d/%0b@%0d", i, obs_q[i].sum, obs_q[i].ovf, obs_q[i].cyc, exp_q[i].sum, exp_q[i].ovf, exp_q[i].cyc); end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_multi_bubble;
        test_saturation;
        test_back_to_back;
        test_restart;
        test_reset_mid_window;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
